// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC/IR/MAR/MDR/Y/HI/LO/Z registers and a 64-bit ALU.
// One shared bus driven by a prioritised select mux; every register loads from it on enable.
module data_path (
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        In_Portout,
  input  logic        Cout,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        Clock,
  input  logic        clear,
  input  logic        Zin_high,
  input  logic        Zin_low,
  input  logic        HIin,
  input  logic        LOin,
  input  logic [31:0] Mdatain,
  input  logic [3:0]  operation,
  output logic [31:0] bus_out
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_SUB  = 4'b0011,
    OP_SHR = 4'b0100, OP_SHL = 4'b0101, OP_ROL = 4'b0110, OP_ROR  = 4'b0111,
    OP_SHRA = 4'b1000, OP_MUL = 4'b1001, OP_DIV = 4'b1010, OP_NEG = 4'b1011,
    OP_NOT = 4'b1100
  } alu_op_e;

  logic [31:0] r_q [16];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zhi_q, zlo_q;

  logic [15:0] r_out_sel, r_in_en;
  logic [31:0] bus, c_ext;

  assign r_out_sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in_en   = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign c_ext     = {{13{ir_q[18]}}, ir_q[18:0]};

  // Descending scan so the lowest-numbered asserted register wins.
  always_comb begin
    bus = '0;
    if (|r_out_sel) begin
      for (int i = 15; i >= 0; i--) begin
        if (r_out_sel[i]) bus = r_q[i];
      end
    end
    else if (HIout)      bus = hi_q;
    else if (LOout)      bus = lo_q;
    else if (Zhighout)   bus = zhi_q;
    else if (Zlowout)    bus = zlo_q;
    else if (PCout)      bus = pc_q;
    else if (MDRout)     bus = mdr_q;
    else if (In_Portout) bus = 32'h0;
    else if (Cout)       bus = c_ext;
  end

  assign bus_out = bus;

  // ALU: A = Y, B = bus.
  logic [31:0]        a, b, sra, quot, rem;
  logic [4:0]         shamt;
  logic [63:0]        rol_w, ror_w, alu_res;
  logic signed [63:0] prod;

  assign a     = y_q;
  assign b     = bus;
  assign shamt = b[4:0];
  assign rol_w = {a, a} << shamt;
  assign ror_w = {a, a} >> shamt;
  assign sra   = $signed(a) >>> shamt;
  assign prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign quot  = (b == 32'h0) ? 32'h0 : $signed(a) / $signed(b);
  assign rem   = (b == 32'h0) ? 32'h0 : $signed(a) % $signed(b);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    alu_res = '0;
    if (IncPC) begin
      alu_res[31:0] = b + 32'd1;
    end
    else begin
      case (alu_op_e'(operation))
        OP_AND:  alu_res[31:0] = a & b;
        OP_OR:   alu_res[31:0] = a | b;
        OP_ADD:  alu_res[31:0] = a + b;
        OP_SUB:  alu_res[31:0] = a - b;
        OP_SHR:  alu_res[31:0] = a >> shamt;
        OP_SHL:  alu_res[31:0] = a << shamt;
        OP_ROL:  alu_res[31:0] = rol_w[63:32];
        OP_ROR:  alu_res[31:0] = ror_w[31:0];
        OP_SHRA: alu_res[31:0] = sra;
        OP_MUL:  alu_res       = prod;
        OP_DIV:  alu_res       = {rem, quot};
        OP_NEG:  alu_res[31:0] = 32'h0 - b;
        OP_NOT:  alu_res[31:0] = ~b;
        default: alu_res       = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the register file is reset too, since
  // clear is defined to zero every register, not just control state.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end
    else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in_en[i]) r_q[i] <= bus;
      end
      if (PCin)     pc_q  <= bus;
      if (IRin)     ir_q  <= bus;
      if (MARin)    mar_q <= bus;
      if (MDRin)    mdr_q <= Read ? Mdatain : bus;
      if (Yin)      y_q   <= bus;
      // A floating HIin/LOin evaluates false in the if, so the register holds.
      if (HIin)     hi_q  <= bus;
      if (LOin)     lo_q  <= bus;
      if (Zin_high) zhi_q <= alu_res[63:32];
      if (Zin_low)  zlo_q <= alu_res[31:0];
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed micro-step bench for data_path: each step asserts strobes for one clock,
// registers are observed by driving them onto the bus.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        clear;
  logic        pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inp_out, c_out;
  logic [15:0] r_out, r_in;
  logic        mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, rd;
  logic        zin_hi, zin_lo, hi_in, lo_in;
  logic [31:0] mdatain;
  logic [3:0]  op;
  logic [31:0] bus_out;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  data_path dut (
    .PCout(pc_out), .Zlowout(zlo_out), .Zhighout(zhi_out), .HIout(hi_out), .LOout(lo_out),
    .MDRout(mdr_out), .In_Portout(inp_out), .Cout(c_out),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .MARin(mar_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in), .Yin(y_in),
    .IncPC(inc_pc), .Read(rd),
    .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
    .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
    .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .Clock(Clock), .clear(clear), .Zin_high(zin_hi), .Zin_low(zin_lo),
    .HIin(hi_in), .LOin(lo_in), .Mdatain(mdatain), .operation(op), .bus_out(bus_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    pc_out = 0; zlo_out = 0; zhi_out = 0; hi_out = 0; lo_out = 0; mdr_out = 0;
    inp_out = 0; c_out = 0; r_out = '0; r_in = '0;
    mar_in = 0; pc_in = 0; mdr_in = 0; ir_in = 0; y_in = 0; inc_pc = 0; rd = 0;
    zin_hi = 0; zin_lo = 0; hi_in = 0; lo_in = 0; op = 4'h0;
  endtask

  // One micro-step: strobes set by the caller are held across the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    mdatain = v; rd = 1; mdr_in = 1;
    tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    mdr_out = 1; y_in = 1;
    tick();
  endtask

  // Y = ya, B = yb via MDR, capture both Z halves.
  task automatic alu_op(input logic [31:0] ya, input logic [31:0] yb, input logic [3:0] code);
    set_y(ya);
    load_mdr(yb);
    mdr_out = 1; op = code; zin_hi = 1; zin_lo = 1;
    tick();
  endtask

  task automatic peek_r(input int n, input string tag, input logic [31:0] exp);
    r_out[n] = 1'b1; #1;
    check(tag, bus_out, exp);
    r_out[n] = 1'b0;
  endtask

  task automatic peek_z(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    zhi_out = 1; #1; check({tag, "_zhi"}, bus_out, exp_hi); zhi_out = 0;
    zlo_out = 1; #1; check({tag, "_zlo"}, bus_out, exp_lo); zlo_out = 0;
  endtask

  initial begin
    idle();
    mdatain = '0;
    clear = 1'b1;
    #12;
    check("reset_bus_idle", bus_out, 32'h0);
    pc_out = 1; #1; check("reset_pc", bus_out, 32'h0); pc_out = 0;
    @(posedge Clock); #1;
    clear = 1'b0;

    // Memory data into R6 and R4.
    load_mdr(32'd66);
    mdr_out = 1; r_in[6] = 1; tick();
    peek_r(6, "r6_load", 32'd66);
    load_mdr(32'd22);
    mdr_out = 1; r_in[4] = 1; tick();
    peek_r(4, "r4_load", 32'd22);

    // 66 rol 22 into R0.
    r_out[6] = 1; y_in = 1; tick();
    r_out[4] = 1; op = 4'b0110; zin_lo = 1; tick();
    zlo_out = 1; r_in[0] = 1; tick();
    peek_r(0, "r0_rol", 32'h1080_0000);

    // PC increment from 0.
    pc_out = 1; mar_in = 1; inc_pc = 1; zin_lo = 1; tick();
    zlo_out = 1; pc_in = 1; tick();
    pc_out = 1; #1; check("pc_inc", bus_out, 32'd1); pc_out = 0;

    // PC wrap at all-ones.
    load_mdr(32'hFFFF_FFFF);
    mdr_out = 1; pc_in = 1; tick();
    pc_out = 1; inc_pc = 1; zin_lo = 1; zin_hi = 1; tick();
    peek_z("pc_wrap", 32'h0, 32'h0);

    alu_op(32'hFFFF_FFFE, 32'd3, 4'b1001); peek_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    alu_op(32'd7, 32'd2, 4'b1010);         peek_z("div", 32'd1, 32'd3);
    alu_op(32'd7, 32'd0, 4'b1010);         peek_z("div0", 32'h0, 32'h0);
    alu_op(32'd5, 32'd7, 4'b0011);         peek_z("sub", 32'h0, 32'hFFFF_FFFE);
    alu_op(32'h8000_0000, 32'd4, 4'b1000); peek_z("shra", 32'h0, 32'hF800_0000);
    alu_op(32'h1234_5678, 32'h0F0F_0F0F, 4'b0000); peek_z("and", 32'h0, 32'h0204_0608);
    alu_op(32'h0, 32'd5, 4'b1011);         peek_z("neg", 32'h0, 32'hFFFF_FFFB);
    alu_op(32'h1, 32'd1, 4'b1111);         peek_z("op_unused", 32'h0, 32'h0);

    // Load-and-drive MDR: old value on the bus during the cycle, new value after the edge.
    load_mdr(32'hAAAA_0001);
    mdr_out = 1; mdr_in = 1; rd = 1; mdatain = 32'h5555_0002; #1;
    check("mdr_old_drives", bus_out, 32'hAAAA_0001);
    tick();
    mdr_out = 1; #1; check("mdr_new_loaded", bus_out, 32'h5555_0002); mdr_out = 0;

    // Multicast into R2, R5 and HI, then priority R2 > R5 > HI > PC.
    load_mdr(32'hCAFE_F00D);
    mdr_out = 1; r_in[2] = 1; r_in[5] = 1; hi_in = 1; tick();
    peek_r(5, "multicast_r5", 32'hCAFE_F00D);
    hi_out = 1; #1; check("multicast_hi", bus_out, 32'hCAFE_F00D); hi_out = 0;
    load_mdr(32'h0000_1111);
    mdr_out = 1; r_in[5] = 1; tick();
    r_out[2] = 1; r_out[5] = 1; hi_out = 1; pc_out = 1; #1;
    check("prio_r2_over_r5", bus_out, 32'hCAFE_F00D);
    idle();
    hi_out = 1; pc_out = 1; mdr_out = 1; #1;
    check("prio_hi_over_pc", bus_out, 32'hCAFE_F00D);
    idle();

    // Cout sign-extends IR[18:0]; In_Port reads zero.
    load_mdr(32'h1234_0001 | 32'h0004_0000);
    mdr_out = 1; ir_in = 1; tick();
    c_out = 1; #1; check("cout_sext", bus_out, 32'hFFFC_0001); c_out = 0;
    inp_out = 1; #1; check("inport_zero", bus_out, 32'h0); inp_out = 0;

    // Asynchronous clear mid-cycle.
    peek_r(6, "r6_before_clear", 32'd66);
    @(posedge Clock); #3;
    clear = 1'b1; #1;
    peek_r(6, "clear_r6", 32'h0);
    pc_out = 1; #1; check("clear_pc", bus_out, 32'h0); pc_out = 0;
    peek_z("clear", 32'h0, 32'h0);
    check("clear_bus_idle", bus_out, 32'h0);
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
